// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the lane extract/merge helpers used by the alignment logic.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } lsu_state_t;

    // Misaligned access or funct3 with no meaning for this direction.
    function automatic logic lsu_is_err(input logic store, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Pick the addressed byte/half out of a word and sign- or zero-extend it.
    function automatic logic [31:0] lsu_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'b0, b};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the low byte/half of the store data onto the old word.
    function automatic logic [31:0] lsu_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
        logic [31:0] r;
        r = old_word;
        case (f3)
            F3_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment: extended load data and read-modify-write merge.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        lane_i,
    input  logic [DATA_W-1:0] rd_word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] merged_o
);

    assign load_data_o = lsu_extract(funct3_i, lane_i, rd_word_i);
    assign merged_o    = lsu_merge(funct3_i, lane_i, rd_word_i, wdata_i);

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one RV32I load/store per handshake against a single-port,
// byte-enable-less word memory. Sub-word stores are read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_dat,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] m_rd_dat
);

    lsu_state_t        state_q, state_d;
    logic              xfer, req_err;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wr_dat_q, m_wr_dat_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] load_data, merged_data;

    // Ready is withheld while reset is held so nothing is accepted during reset.
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign xfer      = req_valid && req_ready;
    assign req_err   = lsu_is_err(req_store, req_funct3, req_addr[1:0]);

    assign m_addr     = m_addr_q;
    assign m_wr_dat   = m_wr_dat_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i    (funct3_q),
        .lane_i      (lane_q),
        .rd_word_i   (m_rd_dat),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_data)
    );

    // Capture request fields on transfer; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (xfer) begin
            funct3_q <= req_funct3;
            store_q  <= req_store;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
        end
    end

    // Next-state and registered-output decode; strobes default low so each lasts one cycle.
    always_comb begin
        state_d      = state_q;
        m_addr_d     = m_addr_q;
        m_wr_dat_d   = m_wr_dat_q;
        mem_rd_en_d  = 1'b0;
        mem_wr_en_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        m_addr_d = {2'b00, req_addr[ADDR_W-1:2]};
                        if (req_store && (req_funct3 == F3_W)) begin
                            state_d     = S_WR;
                            mem_wr_en_d = 1'b1;
                            m_wr_dat_d  = req_wdata;
                        end else begin
                            state_d     = S_RD;
                            mem_rd_en_d = 1'b1;
                        end
                    end
                end
            end
            S_RD:      state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (store_q) begin
                    state_d     = S_WR;
                    m_wr_dat_d  = merged_data;
                    mem_wr_en_d = 1'b1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            m_addr_q     <= '0;
            m_wr_dat_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_addr_q     <= m_addr_d;
            m_wr_dat_q   <= m_wr_dat_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1-cycle registered word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, m_addr, m_wr_dat, m_rd_dat;
    logic        mem_rd_en, mem_wr_en;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];
    int rd_tot = 0, wr_tot = 0, both_tot = 0, xfer_tot = 0;
    logic [31:0] last_wr_addr, last_wr_dat;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .m_addr(m_addr), .m_wr_dat(m_wr_dat),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .m_rd_dat(m_rd_dat)
    );

    always #5 clk = ~clk;

    // data_memory model: registered read, zero when not reading
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[m_addr[5:0]] <= m_wr_dat;
            last_wr_addr     <= m_addr;
            last_wr_dat      <= m_wr_dat;
        end
        m_rd_dat <= mem_rd_en ? mem[m_addr[5:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_rd_en) rd_tot <= rd_tot + 1;
        if (mem_wr_en) wr_tot <= wr_tot + 1;
        if (mem_rd_en && mem_wr_en) both_tot <= both_tot + 1;
        if (req_valid && req_ready) xfer_tot <= xfer_tot + 1;
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nrd, output int nwr);
        int r0, w0;
        r0 = rd_tot; w0 = wr_tot;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        @(posedge clk); #1;
        nrd = rd_tot - r0; nwr = wr_tot - w0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_err, mem_rd_en, mem_wr_en, m_addr, m_wr_dat, resp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%b rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
                     resp_valid, resp_err, mem_rd_en, mem_wr_en, m_addr, m_wr_dat, resp_rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_word;
        int lat, nrd, nwr; logic [31:0] rd; logic er;
        issue(1'b1, 3'b010, 32'h10, 32'h8899_AABB, lat, rd, er, nrd, nwr);
        checks++;
        if ({lat, nrd, nwr, er, rd} !== {32'd2, 32'd0, 32'd1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL sw_preload: lat=%0d rd=%0d wr=%0d err=%b rdata=%h want 2 0 1 0 0", lat, nrd, nwr, er, rd);
        end
        issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, lat, rd, er, nrd, nwr);
        checks++;
        if ({lat, nrd, nwr} !== {32'd2, 32'd0, 32'd1}) begin
            errors++; $display("FAIL sw_timing: lat=%0d rd=%0d wr=%0d want 2 0 1", lat, nrd, nwr);
        end
        checks++;
        if ({last_wr_addr, last_wr_dat, mem[8]} !== {32'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL sw_port: addr=%h dat=%h mem8=%h want 8 deadbeef deadbeef", last_wr_addr, last_wr_dat, mem[8]);
        end
    endtask

    task automatic test_loads;
        int lat, nrd, nwr; logic [31:0] rd; logic er;
        issue(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({rd, er, lat, nrd, nwr} !== {32'hFFFF_FF88, 1'b0, 32'd3, 32'd1, 32'd0}) begin
            errors++; $display("FAIL lb_13: rdata=%h err=%b lat=%0d rd=%0d wr=%0d want ffffff88 0 3 1 0", rd, er, lat, nrd, nwr);
        end
        issue(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({rd, er} !== {32'h0000_8899, 1'b0}) begin errors++; $display("FAIL lhu_12: got %h/%b want 00008899/0", rd, er); end
        issue(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({rd, er} !== {32'hFFFF_AABB, 1'b0}) begin errors++; $display("FAIL lh_10: got %h/%b want ffffaabb/0", rd, er); end
        issue(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL lbu_11: got %h want 000000aa", rd); end
        issue(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({rd, lat} !== {32'h8899_AABB, 32'd3}) begin errors++; $display("FAIL lw_10: got %h lat=%0d want 8899aabb 3", rd, lat); end
    endtask

    task automatic test_hold;
        int n; logic [31:0] r; logic e;
        resp_ready = 1'b0;
        req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h12; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        r = resp_rdata; e = resp_err;
        checks++;
        if ({resp_valid, r, e} !== {1'b1, 32'hFFFF_FF99, 1'b0}) begin
            errors++; $display("FAIL hold_first: v=%b rdata=%h err=%b want 1 ffffff99 0", resp_valid, r, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, resp_rdata, resp_err, req_ready} !== {1'b1, r, e, 1'b0}) begin
                errors++; $display("FAIL hold_stable: v=%b rdata=%h err=%b rdy=%b want 1 %h %b 0", resp_valid, resp_rdata, resp_err, req_ready, r, e);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({resp_valid, resp_rdata, resp_err, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL hold_release: v=%b rdata=%h err=%b rdy=%b want 0 0 0 1", resp_valid, resp_rdata, resp_err, req_ready);
        end
    endtask

    task automatic test_sub_store;
        int lat, nrd, nwr; logic [31:0] rd; logic er;
        issue(1'b1, 3'b000, 32'h11, 32'h0000_0055, lat, rd, er, nrd, nwr);
        checks++;
        if ({lat, nrd, nwr, er, rd} !== {32'd4, 32'd1, 32'd1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL sb_timing: lat=%0d rd=%0d wr=%0d err=%b rdata=%h want 4 1 1 0 0", lat, nrd, nwr, er, rd);
        end
        checks++;
        if (mem[4] !== 32'h8899_55BB) begin errors++; $display("FAIL sb_mem: got %h want 889955bb", mem[4]); end
        issue(1'b1, 3'b001, 32'h12, 32'hFFFF_1234, lat, rd, er, nrd, nwr);
        checks++;
        if ({mem[4], lat} !== {32'h1234_55BB, 32'd4}) begin errors++; $display("FAIL sh_mem: got %h lat=%0d want 123455bb 4", mem[4], lat); end
    endtask

    task automatic test_errors;
        int lat, nrd, nwr; logic [31:0] rd; logic er;
        issue(1'b0, 3'b010, 32'h22, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({er, rd, lat, nrd, nwr} !== {1'b1, 32'h0, 32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL lw_misalign: err=%b rdata=%h lat=%0d rd=%0d wr=%0d want 1 0 1 0 0", er, rd, lat, nrd, nwr);
        end
        issue(1'b1, 3'b001, 32'h23, 32'h1111, lat, rd, er, nrd, nwr);
        checks++;
        if ({er, lat, nrd, nwr} !== {1'b1, 32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL sh_misalign: err=%b lat=%0d rd=%0d wr=%0d want 1 1 0 0", er, lat, nrd, nwr);
        end
        issue(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({er, nrd} !== {1'b1, 32'd0}) begin errors++; $display("FAIL bad_load_f3: err=%b rd=%0d want 1 0", er, nrd); end
        issue(1'b1, 3'b100, 32'h10, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if ({er, nwr} !== {1'b1, 32'd0}) begin errors++; $display("FAIL bad_store_f3: err=%b wr=%0d want 1 0", er, nwr); end
        issue(1'b0, 3'b101, 32'h11, 32'h0, lat, rd, er, nrd, nwr);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL lhu_misalign: err=%b want 1", er); end
    endtask

    task automatic test_back_to_back;
        int x0, r0, w0;
        x0 = xfer_tot; r0 = rd_tot; w0 = wr_tot;
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h21; req_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if ({xfer_tot - x0, rd_tot - r0 + wr_tot - w0} !== {32'd3, 32'd0}) begin
            errors++; $display("FAIL b2b_rate: transfers=%0d accesses=%0d want 3 0", xfer_tot - x0, rd_tot - r0 + wr_tot - w0);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: ready=%b want 1", req_ready); end
    endtask

    task automatic test_reset_in_wr;
        int w0;
        w0 = wr_tot;
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'h0000_1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rst_wr_pre: wr_en=%b want 1", mem_wr_en); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_wr_en, resp_valid, req_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_wr_async: wr=%b v=%b rdy=%b want 0 0 0", mem_wr_en, resp_valid, req_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b want 1", req_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, wr_tot - w0} !== {1'b0, 32'd0} || mem[9] === 32'h0000_1234) begin
            errors++; $display("FAIL rst_wr_drop: v=%b writes=%0d mem9=%h want 0 0 not-00001234", resp_valid, wr_tot - w0, mem[9]);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        test_reset();
        test_store_word();
        test_loads();
        test_hold();
        test_sub_store();
        test_errors();
        test_back_to_back();
        test_reset_in_wr();
        checks++;
        if (both_tot !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_tot); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
